// File: rtl/csa_seq_add_ctrl.sv
// Multi-cycle add/subtract sequencer: one 4-bit carry-skip slice is time-shared,
// one nibble per clock, LSB first, with the inter-nibble carry held in a register.

module carry_skip_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       carry
);
   logic [3:0] w_p;
   logic [3:0] w_g;
   logic       w_c1;
   logic       w_c2;
   logic       w_c3;
   logic       w_c4;

   assign w_p  = a ^ b;
   assign w_g  = a & b;
   assign w_c1 = w_g[0] | (w_p[0] & cin);
   assign w_c2 = w_g[1] | (w_p[1] & w_c1);
   assign w_c3 = w_g[2] | (w_p[2] & w_c2);
   assign w_c4 = w_g[3] | (w_p[3] & w_c3);
   assign sum  = w_p ^ {w_c3, w_c2, w_c1, cin};
   // When every bit propagates, the incoming carry bypasses the ripple chain.
   assign carry = (&w_p) ? cin : w_c4;
endmodule

module csa_seq_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   generate
      if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_bad_width
         $error("csa_seq_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
      end
   endgenerate

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_ovf;

   logic [3:0]       w_a_nib;
   logic [3:0]       w_b_nib;
   logic [3:0]       w_sum;
   logic             w_carry;
   logic             w_last;
   logic             w_accept;

   assign w_a_nib  = r_a[{r_cnt, 2'b00} +: 4];
   assign w_b_nib  = r_b[{r_cnt, 2'b00} +: 4];
   assign w_last   = (r_cnt == CW'(NIB - 1));
   assign in_ready = (r_state == S_IDLE) & rst_n;
   assign w_accept = in_valid & in_ready;

   carry_skip_adder u_slice (
      .a     (w_a_nib),
      .b     (w_b_nib),
      .cin   (r_carry),
      .sum   (w_sum),
      .carry (w_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  // Subtract is a + ~b + 1, so the +1 rides in as the first carry.
                  r_a      <= a;
                  r_b      <= op ? ~b : b;
                  r_carry  <= op ? 1'b1 : cin;
                  r_result <= '0;
                  r_cnt    <= '0;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               r_result[{r_cnt, 2'b00} +: 4] <= w_sum;
               r_carry <= w_carry;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_cout  <= w_carry;
                  r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[3] != r_a[WIDTH-1]);
                  r_cnt   <= '0;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign result    = r_result;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
endmodule

// File: tb/tb_csa_seq_add_ctrl.sv
// Bench for csa_seq_add_ctrl: directed add/subtract vectors against a transaction-level
// arithmetic model, with a per-cycle compare process and literal spot checks.

module tb_csa_seq_add_ctrl;
   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         busy;

   int n_cmp  = 0;
   int n_fail = 0;

   csa_seq_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Returns {ovf, cout, result} from plain integer arithmetic.
   function automatic logic [W+1:0] model_op(input logic o, input logic [W-1:0] x,
                                             input logic [W-1:0] y, input logic ci);
      longint ux, uy, s, sx, sy, ss;
      logic [W-1:0] r;
      logic c, v;
      ux = x;
      uy = y;
      sx = $signed(x);
      sy = $signed(y);
      if (o) begin
         s  = ux - uy;
         c  = (ux >= uy);
         ss = sx - sy;
      end else begin
         s  = ux + uy + longint'(ci);
         c  = s[W];
         ss = sx + sy + longint'(ci);
      end
      r = s[W-1:0];
      v = (ss > longint'((1 << (W-1)) - 1)) || (ss < -longint'(1 << (W-1)));
      return {v, c, r};
   endfunction

   bit           m_idle;
   bit           m_valid;
   int           m_left;
   logic [W-1:0] m_res, m_pend_res;
   logic         m_cout, m_ovf, m_pend_cout, m_pend_ovf;

   initial begin
      m_idle  = 1;
      m_valid = 0;
      m_left  = 0;
      m_res   = '0;
      m_cout  = 0;
      m_ovf   = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_idle  = 1;
            m_valid = 0;
            m_left  = 0;
            m_res   = '0;
            m_cout  = 0;
            m_ovf   = 0;
         end else if (m_idle) begin
            if (in_valid) begin
               {m_pend_ovf, m_pend_cout, m_pend_res} = model_op(op, a, b, cin);
               m_idle = 0;
               m_left = NIB;
               m_res  = '0;
            end
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_valid = 1;
               m_res   = m_pend_res;
               m_cout  = m_pend_cout;
               m_ovf   = m_pend_ovf;
            end
         end else if (out_ready) begin
            m_valid = 0;
            m_idle  = 1;
         end
         #2;
         chk("cyc_in_ready", in_ready, (m_idle && rst_n));
         chk("cyc_out_valid", out_valid, m_valid);
         chk("cyc_busy", busy, !m_idle);
         if (m_idle || m_valid) begin
            chk("cyc_result", result, m_res);
            chk("cyc_cout", cout, m_cout);
            chk("cyc_ovf", ovf, m_ovf);
         end
      end
   end

   task automatic wait_valid(input string tag, output int lat);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) in_valid = 1'b0;
         if (out_valid) begin
            lat = k;
            break;
         end
         chk({tag, "_in_ready_run"}, in_ready, 0);
      end
   endtask

   task automatic run_op(input string tag, input logic o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ci, input logic [W-1:0] er,
                         input logic ec, input logic eo);
      int lat;
      in_valid = 1'b1;
      op  = o;
      a   = x;
      b   = y;
      cin = ci;
      wait_valid(tag, lat);
      chk({tag, "_latency"}, lat, NIB + 1);
      chk({tag, "_result"}, result, er);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_ovf"}, ovf, eo);
      @(negedge clk);
      chk({tag, "_after_out_valid"}, out_valid, 0);
      chk({tag, "_after_in_ready"}, in_ready, 1);
   endtask

   initial begin
      int lat;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      out_ready = 1'b1;

      chk("model_sub_neg", model_op(1'b1, 16'h0005, 16'h0007, 1'b1), {2'b00, 16'hFFFE});
      chk("model_add_ovf", model_op(1'b0, 16'h7FFF, 16'h0001, 1'b0), {2'b10, 16'h8000});

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_busy", busy, 0);

      run_op("add_basic",  1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      run_op("add_ripple", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_op("add_ovf",    1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("sub_neg",    1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_ovf",    1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);

      // Backpressure: result must hold while the producer side keeps changing.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      op  = 1'b0;
      a   = 16'h00F0;
      b   = 16'h0F10;
      cin = 1'b0;
      wait_valid("bp", lat);
      chk("bp_latency", lat, NIB + 1);
      for (int i = 0; i < 3; i++) begin
         in_valid = (i % 2 == 0);
         op  = (i % 2 == 1);
         a   = W'($urandom);
         b   = W'($urandom);
         cin = 1'b1;
         @(negedge clk);
         chk("bp_hold_result", result, 16'h1000);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_persist_result", result, 16'h1000);
      in_valid = 1'b1;
      op  = 1'b0;
      a   = 16'h0003;
      b   = 16'h0004;
      cin = 1'b0;
      wait_valid("bp_next", lat);
      chk("bp_next_latency", lat, NIB + 1);
      chk("bp_next_result", result, 16'h0007);
      @(negedge clk);

      // Abort during the second RUN cycle.
      in_valid = 1'b1;
      op  = 1'b0;
      a   = 16'h1234;
      b   = 16'h1111;
      cin = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_result", result, 0);
      chk("abort_cout", cout, 0);
      chk("abort_ovf", ovf, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_valid", out_valid, 0);
      end
      run_op("after_abort", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
